ul4_arbiter: RTL and testbench
==============================

// Module: ul4_arbiter
// PURPOSE
//   Shares one 4-bit logic unit (AND/OR/XOR/NOT) between two requesters.
//   Round-robin arbitration, operand latching, sequencing of the unit's A/B/S inputs,
//   and capture of its Out into a registered result with a done pulse and requester ID.
//   Sits between the two client blocks and the logic unit; the logic unit connects to ul_*.
// PARAMETERS
//   WIDTH    4  operand/result width; must match the attached logic unit
//   RES_LAT  1  cycles in EXEC before ul_out is sampled; legal 1..15
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   req0     in   1      requester 0 request; hold high until ack0
//   a0, b0   in   WIDTH  requester 0 operands
//   s0       in   2      requester 0 op: 00 AND, 01 OR, 10 XOR, 11 NOT A
//   req1     in   1      requester 1 request; hold high until ack1
//   a1, b1   in   WIDTH  requester 1 operands
//   s1       in   2      requester 1 op select
//   ack0     out  1      1-cycle pulse: requester 0 operands latched
//   ack1     out  1      1-cycle pulse: requester 1 operands latched
//   busy     out  1      high in EXEC and DONE
//   done     out  1      1-cycle pulse: res valid
//   done_id  out  1      requester owning res (0/1)
//   res      out  WIDTH  registered result; held until next capture
//   ul_a     out  WIDTH  to logic unit A
//   ul_b     out  WIDTH  to logic unit B
//   ul_s     out  2      to logic unit S
//   ul_out   in   WIDTH  from logic unit Out (combinational)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; ack0/ack1/busy/done/done_id=0; res=0;
//     ul_a/ul_b/ul_s=0; prio=0 (requester 0 favoured); counter=0. Takes effect immediately.
//   FSM: IDLE -> EXEC -> DONE -> IDLE. All outputs are registered (Moore).
//   IDLE: at edge E0, if req0|req1 -> pick winner:
//     - one requesting: that one.
//     - both requesting: the one equal to prio.
//     - latch winner's a/b/s into ul_a/ul_b/ul_s; owner<=winner; prio<=~winner;
//       ackN=1 for the cycle after E0; cnt<=RES_LAT; go to EXEC.
//     - no request: stay in IDLE; all pulses 0.
//   EXEC: ul_* held stable; cnt decrements each edge. At edge E0+RES_LAT:
//     res<=ul_out; done<=1; done_id<=owner; go to DONE.
//     ul_out values before that edge are ignored.
//   DONE: lasts exactly 1 cycle (done high), then returns to IDLE at edge E0+RES_LAT+1.
//     Earliest next acceptance is edge E0+RES_LAT+2.
//   Requests arriving in EXEC/DONE are not acknowledged; they wait.
//     A requester still high in IDLE after its ack is treated as a new request.
//   ul_a/ul_b/ul_s keep their last operands after DONE until the next acceptance.
//   res holds its value between operations.
//   s=11 (NOT A): b is passed through to ul_b but does not affect res.
//   Reset mid-operation: in-flight op discarded; no done; prio back to 0.
//   RES_LAT outside 1..15: illegal; flagged by simulation-time check.
// TESTING
//   T1 req0, a0=1010, b0=1100, s0=00, RES_LAT=1:
//      ack0 one cycle after E0; done=1, done_id=0, res=1000 in cycle after E0+1.
//   T2 after reset, req0 (1010 OR 1100) and req1 (1010 XOR 1100) same edge:
//      first done id 0 res=1110; then id 1 res=0110; gap between acks = 3 cycles.
//   T3 req0 and req1 held high continuously, with re-issue after each ack:
//      done_id sequence 0,1,0,1 over 4 ops; ack0/ack1 never both high.
//   T4 req1, a1=1010, s1=11, b1=1111: res=0101, done_id=1.
//   T5 rst_n low during EXEC of req0:
//      all outputs 0 immediately; no done.
//      After release, simultaneous req0/req1: req0 granted first.
//   T6 RES_LAT=3, ul_out glitched via forced values in EXEC:
//      res equals ul_out at edge E0+3 only; done exactly one cycle; busy high 4 cycles.

Source files
------------

// File: rtl/ul4_arbiter_if.sv
// Bundle between two requesters, the arbiter and the shared 4-bit logic unit.
// master = requesters plus logic unit side; slave = the arbiter.
interface ul4_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [1:0]       s0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       s1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] ul_a;
  logic [WIDTH-1:0] ul_b;
  logic [1:0]       ul_s;
  logic [WIDTH-1:0] ul_out;

  modport master (
    output req0, a0, b0, s0, req1, a1, b1, s1, ul_out,
    input  ack0, ack1, busy, done, done_id, res, ul_a, ul_b, ul_s
  );

  modport slave (
    input  req0, a0, b0, s0, req1, a1, b1, s1, ul_out,
    output ack0, ack1, busy, done, done_id, res, ul_a, ul_b, ul_s
  );
endinterface

// File: rtl/ul4_arbiter.sv
// Round-robin sharing of one combinational logic unit between two requesters.
// Latches the winner's operands, waits RES_LAT cycles, then registers the unit's output.
module ul4_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RES_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  ul4_arbiter_if.slave  bus
);

  if (RES_LAT < 1 || RES_LAT > 15) begin : g_bad_res_lat
    $error("ul4_arbiter: RES_LAT must be within 1..15");
  end

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e     state_q;
  logic       prio_q;
  logic       owner_q;
  logic [3:0] cnt_q;
  logic       grant1;

  // Requester 1 wins when it is alone or when both ask and it holds priority.
  always_comb begin
    grant1 = bus.req1 & (~bus.req0 | prio_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= 1'b0;
      bus.res     <= '0;
      bus.ul_a    <= '0;
      bus.ul_b    <= '0;
      bus.ul_s    <= 2'b00;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req0 || bus.req1) begin
            if (grant1) begin
              bus.ul_a <= bus.a1;
              bus.ul_b <= bus.b1;
              bus.ul_s <= bus.s1;
              bus.ack1 <= 1'b1;
            end else begin
              bus.ul_a <= bus.a0;
              bus.ul_b <= bus.b0;
              bus.ul_s <= bus.s0;
              bus.ack0 <= 1'b1;
            end
            owner_q  <= grant1;
            prio_q   <= ~grant1;
            cnt_q    <= 4'(RES_LAT);
            bus.busy <= 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == 4'd1) begin
            bus.res     <= bus.ul_out[WIDTH-1:0];
            bus.done    <= 1'b1;
            bus.done_id <= owner_q;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ul4_arbiter.sv
// Bench for ul4_arbiter: vector table with a result scoreboard, plus reset,
// back-to-back and long-latency sequences on a second instance.
module tb_ul4_arbiter;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ul4_arbiter_if #(.WIDTH(4)) bus1 ();
  ul4_arbiter_if #(.WIDTH(4)) bus3 ();

  ul4_arbiter #(.WIDTH(4), .RES_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ul4_arbiter #(.WIDTH(4), .RES_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic [3:0] lu(input logic [3:0] a, input logic [3:0] b,
                                    input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  logic       glitch_en;
  logic [3:0] glitch_val;
  assign bus1.ul_out = lu(bus1.ul_a, bus1.ul_b, bus1.ul_s);
  assign bus3.ul_out = glitch_en ? glitch_val : lu(bus3.ul_a, bus3.ul_b, bus3.ul_s);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  typedef struct {
    logic       id;
    logic [3:0] res;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: every done must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus1.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_id", bus1.done_id, e.id);
        check("res", bus1.res, e.res);
      end
    end
    if (rst_n && (bus1.ack0 || bus1.ack1)) check("ack_exclusive", bus1.ack0 & bus1.ack1, 0);
  end

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [1:0] s0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [1:0] s1;
    logic       first;
    logic [3:0] res0;
    logic [3:0] res1;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_sb(input string name);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      timeout(name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic push(input logic id, input logic [3:0] res);
    exp_t e;
    e.id  = id;
    e.res = res;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit got0, got1;
    int cyc = 0, c_first = 0, c_second = 0, n_acks = 0;
    logic id_first = 1'b0;
    if (v.r0 && v.r1) begin
      push(v.first, v.first ? v.res1 : v.res0);
      push(~v.first, v.first ? v.res0 : v.res1);
    end else if (v.r0) begin
      push(1'b0, v.res0);
    end else begin
      push(1'b1, v.res1);
    end
    bus1.req0 = v.r0; bus1.a0 = v.a0; bus1.b0 = v.b0; bus1.s0 = v.s0;
    bus1.req1 = v.r1; bus1.a1 = v.a1; bus1.b1 = v.b1; bus1.s1 = v.s1;
    got0 = !v.r0;
    got1 = !v.r1;
    while (!(got0 && got1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus1.ack0 || bus1.ack1) begin
        n_acks++;
        if (n_acks == 1) begin
          c_first  = cyc;
          id_first = bus1.ack1;
        end else begin
          c_second = cyc;
        end
      end
      if (bus1.ack0) begin got0 = 1; bus1.req0 = 1'b0; end
      if (bus1.ack1) begin got1 = 1; bus1.req1 = 1'b0; end
    end
    if (!(got0 && got1)) begin
      timeout({name, "_ack"});
      bus1.req0 = 1'b0;
      bus1.req1 = 1'b0;
    end else begin
      check({name, "_first_id"}, id_first, v.first);
      check({name, "_ack_latency"}, c_first, 1);
      if (v.r0 && v.r1) check({name, "_ack_gap"}, c_second - c_first, 3);
    end
    wait_sb({name, "_done"});
  endtask

  initial begin
    int busy_cnt, done_cnt, done_k, n;
    logic [3:0] res_s;
    logic       id_s;
    logic       exp_id;
    bit         ok;
    logic [3:0] gv[8];
    vec_t       t2;

    vecs[0] = '{1'b1, 1'b0, 4'b1010, 4'b1100, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b0, 4'b1000, 4'b0000};
    vecs[1] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 4'b1010, 4'b1111, 2'b11, 1'b1, 4'b0000, 4'b0101};
    vecs[2] = '{1'b1, 1'b1, 4'b1010, 4'b1100, 2'b01, 4'b1010, 4'b1100, 2'b10, 1'b0, 4'b1110, 4'b0110};
    vecs[3] = '{1'b1, 1'b1, 4'b0011, 4'b0101, 2'b10, 4'b1111, 4'b1001, 2'b00, 1'b0, 4'b0110, 4'b1001};
    vecs[4] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 4'b0110, 4'b0011, 2'b01, 1'b1, 4'b0000, 4'b0111};
    vecs[5] = '{1'b1, 1'b0, 4'b1100, 4'b0000, 2'b11, 4'b0000, 4'b0000, 2'b00, 1'b0, 4'b0011, 4'b0000};
    vecs[6] = '{1'b1, 1'b1, 4'b0101, 4'b0101, 2'b00, 4'b1111, 4'b0000, 2'b10, 1'b1, 4'b0101, 4'b1111};
    vecs[7] = '{1'b1, 1'b0, 4'b0000, 4'b1010, 2'b11, 4'b0000, 4'b0000, 2'b00, 1'b0, 4'b1111, 4'b0000};

    rst_n = 1'b0;
    glitch_en = 1'b0; glitch_val = 4'b0000;
    bus1.req0 = 0; bus1.a0 = 0; bus1.b0 = 0; bus1.s0 = 0;
    bus1.req1 = 0; bus1.a1 = 0; bus1.b1 = 0; bus1.s1 = 0;
    bus3.req0 = 0; bus3.a0 = 0; bus3.b0 = 0; bus3.s0 = 0;
    bus3.req1 = 0; bus3.a1 = 0; bus3.b1 = 0; bus3.s1 = 0;
    #12;
    check("reset_busy", bus1.busy, 0);
    check("reset_done", bus1.done, 0);
    check("reset_res", bus1.res, 0);
    check("reset_ul", {bus1.ul_a, bus1.ul_b, bus1.ul_s}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while req0's operation is in EXEC: everything clears at once, no done.
    bus1.req0 = 1'b1; bus1.a0 = 4'b1010; bus1.b0 = 4'b1100; bus1.s0 = 2'b01;
    @(negedge clk);
    check("t5_ack0", bus1.ack0, 1);
    bus1.req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_clear_flags", {bus1.ack0, bus1.ack1, bus1.busy, bus1.done, bus1.done_id}, 0);
    check("t5_clear_res", bus1.res, 0);
    check("t5_clear_ul", {bus1.ul_a, bus1.ul_b, bus1.ul_s}, 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("t5_no_done", bus1.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    t2 = '{1'b1, 1'b1, 4'b1010, 4'b1100, 2'b01, 4'b1010, 4'b1100, 2'b10, 1'b0, 4'b1110, 4'b0110};
    run_vec(t2, "t2");

    // Both requests held for four operations: grants must alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) push(i[0], i[0] ? 4'b0100 : 4'b0011);
    bus1.req0 = 1'b1; bus1.a0 = 4'b0001; bus1.b0 = 4'b0011; bus1.s0 = 2'b01;
    bus1.req1 = 1'b1; bus1.a1 = 4'b1000; bus1.b1 = 4'b1100; bus1.s1 = 2'b10;
    n = 0;
    exp_id = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus1.ack0 || bus1.ack1) begin
        check("t3_ack_id", bus1.ack1, exp_id);
        exp_id = ~exp_id;
        n++;
      end
    end
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
    if (n < 4) timeout("t3_acks");
    wait_sb("t3_done");

    // Long latency: only the unit output present at the capture edge may land in res.
    gv[0] = 4'b1110; gv[1] = 4'b0001; gv[2] = 4'b0010; gv[3] = 4'b0111;
    gv[4] = 4'b1111; gv[5] = 4'b1111; gv[6] = 4'b1111; gv[7] = 4'b1111;
    glitch_en = 1'b1;
    glitch_val = gv[0];
    bus3.req0 = 1'b1; bus3.a0 = 4'b1010; bus3.b0 = 4'b1100; bus3.s0 = 2'b00;
    busy_cnt = 0; done_cnt = 0; done_k = 0; res_s = 4'b0000; id_s = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t6_ack0", bus3.ack0, 1);
        bus3.req0 = 1'b0;
      end
      if (bus3.busy) busy_cnt++;
      if (bus3.done) begin
        done_cnt++;
        done_k = k;
        res_s  = bus3.res;
        id_s   = bus3.done_id;
      end
      glitch_val = gv[k];
    end
    check("t6_busy_cycles", busy_cnt, 4);
    check("t6_done_cycles", done_cnt, 1);
    check("t6_done_time", done_k, 4);
    check("t6_res", res_s, 4'b0111);
    check("t6_done_id", id_s, 0);
    check("t6_res_held", bus3.res, 4'b0111);
    glitch_en = 1'b0;

    ok = (sb.size() == 0);
    check("sb_empty", ok, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
